// File: rtl/sap1_prog_loader.sv
// Program SRAM loader for the SAP-1: fills the 16x8 array from a valid/ready byte stream, pads the tail with all-ones,
// and holds the CPU in reset until the image is complete. Define SAP1_LOADER_CKSUM_EN to require a trailing checksum byte.
module sap1_prog_loader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int LOAD_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_ce_n,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit HAS_FILL = (LOAD_LEN < DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LOAD_LEN - 1);
    localparam logic [ADDR_W-1:0] END_PTR  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
`ifdef SAP1_LOADER_CKSUM_EN
        S_CHECK,
        S_ERR,
`endif
        S_RUN
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic [DATA_W-1:0] sum, sum_n, sum_add;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdat;
    logic              hs;

    always_comb begin
        in_ready = (state == S_LOAD);
        busy     = (state == S_LOAD) || (state == S_FILL);
        done     = (state == S_RUN);
        cpu_rst  = (state != S_RUN);
        err      = 1'b0;
`ifdef SAP1_LOADER_CKSUM_EN
        in_ready = in_ready || (state == S_CHECK);
        err      = (state == S_ERR);
`endif
    end

    assign hs      = in_valid && in_ready;
    assign sum_add = sum + in_data;

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        sum_n    = sum;
        mem_we   = 1'b0;
        mem_wdat = in_data;
        case (state)
            S_LOAD: begin
                if (hs) begin
                    mem_we   = 1'b1;
                    wr_ptr_n = wr_ptr + 1'b1;
                    sum_n    = sum_add;
                    if (wr_ptr == LAST_PTR) begin
`ifdef SAP1_LOADER_CKSUM_EN
                        state_n = S_CHECK;
`else
                        state_n = HAS_FILL ? S_FILL : S_RUN;
`endif
                    end
                end
            end
`ifdef SAP1_LOADER_CKSUM_EN
            // wr_ptr already sits at the first fill location; the checksum byte is never stored
            S_CHECK: begin
                if (hs) begin
                    state_n = (sum_add == '0) ? (HAS_FILL ? S_FILL : S_RUN) : S_ERR;
                end
            end
`endif
            S_FILL: begin
                mem_we   = 1'b1;
                mem_wdat = '1;
                wr_ptr_n = wr_ptr + 1'b1;
                if (wr_ptr == END_PTR) begin
                    state_n = S_RUN;
                end
            end
            default: ;
        endcase
        // Restart wins over any pointer update from a byte accepted this cycle
        if (load_start) begin
            state_n  = S_LOAD;
            wr_ptr_n = '0;
            sum_n    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            sum    <= '0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr_n;
            sum    <= sum_n;
        end
    end

    // Array has no reset so a loaded image survives rst
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= mem_wdat;
        end
    end

    assign cpu_data = cpu_ce_n ? '0 : mem[cpu_addr];

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Scoreboard bench for sap1_prog_loader: two instances (LOAD_LEN 16 and 12) share the byte stream and read port.
module tb_sap1_prog_loader;
    typedef enum int {K_ST16, K_ST12, K_RD16, K_RD12, K_CNT, K_TMO} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    // status byte layout: {3'b0, cpu_rst, in_ready, busy, done, err}
    localparam logic [7:0] ST_IDLE  = 8'b000_10000;
    localparam logic [7:0] ST_LOAD  = 8'b000_11100;
    localparam logic [7:0] ST_FILL  = 8'b000_10100;
    localparam logic [7:0] ST_RUN   = 8'b000_00010;
`ifdef SAP1_LOADER_CKSUM_EN
    localparam logic [7:0] ST_CHECK = 8'b000_11000;
    localparam logic [7:0] ST_ERR   = 8'b000_10001;
    localparam logic [7:0] RDY_EXP  = 8'd17;
`else
    localparam logic [7:0] RDY_EXP  = 8'd16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld16 = 1'b0, ld12 = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [3:0] cpu_addr = 4'h0;
    logic       cpu_ce_n = 1'b1;
    logic       cnt_clr = 1'b0;

    logic       rdy16, crst16, busy16, done16, err16;
    logic       rdy12, crst12, busy12, done12, err12;
    logic [7:0] d16, d12;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         rdy_cnt = 0;
    logic [7:0] m16 [16];
    logic [7:0] m12 [16];
    logic [7:0] img [16];
    logic [7:0] s;

    always #5 clk = ~clk;

    sap1_prog_loader #(.ADDR_W(4), .DATA_W(8), .LOAD_LEN(16)) u16 (
        .clk(clk), .rst(rst), .load_start(ld16), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy16), .cpu_addr(cpu_addr), .cpu_ce_n(cpu_ce_n), .cpu_data(d16),
        .cpu_rst(crst16), .busy(busy16), .done(done16), .err(err16)
    );

    sap1_prog_loader #(.ADDR_W(4), .DATA_W(8), .LOAD_LEN(12)) u12 (
        .clk(clk), .rst(rst), .load_start(ld12), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy12), .cpu_addr(cpu_addr), .cpu_ce_n(cpu_ce_n), .cpu_data(d12),
        .cpu_rst(crst12), .busy(busy12), .done(done12), .err(err12)
    );

    // Monitor: outputs are settled at the falling edge; drain every expectation queued for this cycle
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (cnt_clr) rdy_cnt = 0;
            else         rdy_cnt = rdy_cnt + int'(rdy16);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.kind)
                    K_ST16:  act = {3'b000, crst16, rdy16, busy16, done16, err16};
                    K_ST12:  act = {3'b000, crst12, rdy12, busy12, done12, err12};
                    K_RD16:  act = d16;
                    K_RD12:  act = d12;
                    K_CNT:   act = 8'(rdy_cnt);
                    default: act = 8'h00;
                endcase
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input kind_t k, input logic [7:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel12, input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!(sel12 ? rdy12 : rdy16) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) push(K_TMO, 8'h01, "handshake_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic rd(input bit sel12, input logic [3:0] a, input logic [7:0] v, input string n);
        cpu_ce_n = 1'b0;
        cpu_addr = a;
        push(sel12 ? K_RD12 : K_RD16, v, n);
        step();
    endtask

    task automatic chk_mem(input bit sel12, input string n);
        for (int i = 0; i < 16; i++) begin
            rd(sel12, 4'(i), sel12 ? m12[i] : m16[i], $sformatf("%s[%0d]", n, i));
        end
    endtask

    task automatic pulse(input bit sel12);
        if (sel12) ld12 = 1'b1; else ld16 = 1'b1;
        step();
        ld12 = 1'b0;
        ld16 = 1'b0;
    endtask

    initial begin
        img = '{8'h09, 8'h1A, 8'h1B, 8'h2B, 8'hE0, 8'hF0, 8'hFF, 8'hFF,
                8'hFF, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        push(K_ST16, ST_IDLE, "reset_st16");
        push(K_ST12, ST_IDLE, "reset_st12");
        step();
        rst = 1'b0;
        step();

        // 1: full 16-byte image, no fill
        cnt_clr = 1'b1;
        pulse(1'b0);
        cnt_clr = 1'b0;
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push(K_ST16, ST_LOAD, "t1_last_accept_st");
            send(1'b0, img[i]);
            m16[i] = img[i];
            s = s + img[i];
        end
`ifdef SAP1_LOADER_CKSUM_EN
        push(K_ST16, ST_CHECK, "t1_check_st");
        send(1'b0, 8'h00 - s);
`endif
        push(K_ST16, ST_RUN, "t1_done_st");
        push(K_CNT, RDY_EXP, "t1_ready_cycles");
        step();
        n_tests++;
        if (done16 !== 1'b1 || crst16 !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_direct_run: done=%b cpu_rst=%b", done16, crst16);
        end
        rd(1'b0, 4'd9, 8'h01, "t1_rd9");
        rd(1'b0, 4'd0, 8'h09, "t1_rd0");
        cpu_ce_n = 1'b1;
        #1;
        n_tests++;
        if (d16 !== 8'h00) begin
            n_fail++;
            $display("FAIL t1_direct_ce_off: got %h", d16);
        end
        push(K_RD16, 8'h00, "t1_ce_off");
        step();
        chk_mem(1'b0, "t1_mem");

        // 2: 12-byte image, 4 fill cycles
        pulse(1'b1);
        s = 8'h00;
        for (int i = 0; i < 12; i++) begin
            send(1'b1, 8'h10 + 8'(i));
            m12[i] = 8'h10 + 8'(i);
            s = s + m12[i];
        end
`ifdef SAP1_LOADER_CKSUM_EN
        send(1'b1, 8'h00 - s);
`endif
        for (int j = 1; j <= 4; j++) begin
            push(K_ST12, ST_FILL, $sformatf("t2_fill_c%0d", j));
            step();
        end
        push(K_ST12, ST_RUN, "t2_done_c5");
        step();
        n_tests++;
        if (done12 !== 1'b1 || busy12 !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_direct_done: done=%b busy=%b", done12, busy12);
        end
        for (int i = 12; i < 16; i++) m12[i] = 8'hFF;
        chk_mem(1'b1, "t2_mem");

        // 3: gaps in in_valid
        pulse(1'b0);
        begin
            logic       vv [6];
            logic [7:0] dd [6];
            vv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            dd = '{8'hAA, 8'h77, 8'h77, 8'hBB, 8'h77, 8'hCC};
            for (int k = 0; k < 6; k++) begin
                in_valid = vv[k];
                in_data  = dd[k];
                step();
            end
        end
        in_valid = 1'b0;
        m16[0] = 8'hAA;
        m16[1] = 8'hBB;
        m16[2] = 8'hCC;
        push(K_ST16, ST_LOAD, "t3_state");
        step();
        chk_mem(1'b0, "t3_mem");

        // 4: restart with a byte offered in the same cycle
        send(1'b0, 8'hDD);
        send(1'b0, 8'hEE);
        m16[3] = 8'hDD;
        m16[4] = 8'hEE;
        ld16 = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h99;
        step();
        ld16 = 1'b0;
        in_valid = 1'b0;
        m16[5] = 8'h99;
        send(1'b0, 8'h55);
        m16[0] = 8'h55;
        push(K_ST16, ST_LOAD, "t4_state");
        step();
        n_tests++;
        if (done16 !== 1'b0 || crst16 !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_direct_restart: done=%b cpu_rst=%b", done16, crst16);
        end
        chk_mem(1'b0, "t4_mem");

        // 5: reset after 8 bytes
        pulse(1'b0);
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 8'h80 + 8'(i));
            m16[i] = 8'h80 + 8'(i);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (rdy16 !== 1'b0 || busy16 !== 1'b0 || crst16 !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_direct_rst: rdy=%b busy=%b cpu_rst=%b", rdy16, busy16, crst16);
        end
        push(K_ST16, ST_IDLE, "t5_rst_st16");
        push(K_ST12, ST_IDLE, "t5_rst_st12");
        step();
        rst = 1'b0;
        step();
        chk_mem(1'b0, "t5_mem16");
        chk_mem(1'b1, "t5_mem12");

`ifdef SAP1_LOADER_CKSUM_EN
        // 6: bad then good checksum
        pulse(1'b0);
        for (int i = 0; i < 16; i++) begin
            send(1'b0, img[i]);
            m16[i] = img[i];
        end
        send(1'b0, 8'h00);
        push(K_ST16, ST_ERR, "t6_err_st");
        step();
        pulse(1'b0);
        push(K_ST16, ST_LOAD, "t6_err_cleared");
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            send(1'b0, img[i]);
            s = s + img[i];
        end
        send(1'b0, 8'h00 - s);
        push(K_ST16, ST_RUN, "t6_run_st");
        step();
        chk_mem(1'b0, "t6_mem");
`endif

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
